// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Purpose : Bundles the serial line and the byte-side outputs of the UART
//           receiver so they can be passed around as one port.
// Signals :
//   serial_in    - asynchronous serial line, idles high (into the receiver)
//   rx_data      - last received byte
//   rx_valid     - one-cycle strobe when a frame completes
//   frame_error  - stop bit sampled low (qualified by rx_valid, then held)
//   parity_error - parity mismatch (qualified by rx_valid, then held)
//   busy         - receiver is inside a frame
// Modports:
//   master - the receiver: consumes serial_in, drives the byte-side outputs
//   slave  - line driver / byte consumer: drives serial_in, reads the rest
// -----------------------------------------------------------------------------
interface uart_rx_if;
  logic       serial_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       parity_error;
  logic       busy;

  modport master (
    input  serial_in,
    output rx_data,
    output rx_valid,
    output frame_error,
    output parity_error,
    output busy
  );

  modport slave (
    output serial_in,
    input  rx_data,
    input  rx_valid,
    input  frame_error,
    input  parity_error,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Purpose : UART receiver. Recovers LSB-first 8N1 frames (8E1 when the
//           UART_RX_PARITY_EN macro is defined) from an asynchronous serial
//           line and presents each byte with a one-cycle valid strobe.
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit (>= 4)
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-low reset
//   bus   - uart_rx_if.master (serial_in, rx_data, rx_valid, frame_error,
//           parity_error, busy)
// Optional feature:
//   UART_RX_PARITY_EN - adds an even-parity bit after the data bits and
//                       reports mismatches on parity_error; when undefined
//                       parity_error is held at 0.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.master bus
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  // Half a bit into START puts every later sample in the middle of its bit.
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_error_q, frame_error_d;
  logic            parity_error_q, parity_error_d;
  logic            busy_q;
`ifdef UART_RX_PARITY_EN
  logic            parity_bit_q, parity_bit_d;
`endif

  // Two-flop synchronizer for the asynchronous serial line (resets to idle-high).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.serial_in};
    end
  end

  assign rx_s = sync_q[1];

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      timer_q        <= T_ZERO;
      bit_cnt_q      <= 3'd0;
      shift_q        <= 8'h00;
      rx_data_q      <= 8'h00;
      rx_valid_q     <= 1'b0;
      frame_error_q  <= 1'b0;
      parity_error_q <= 1'b0;
      busy_q         <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q   <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      frame_error_q  <= frame_error_d;
      parity_error_q <= parity_error_d;
      busy_q         <= (state_d != IDLE);
`ifdef UART_RX_PARITY_EN
      parity_bit_q   <= parity_bit_d;
`endif
    end
  end

  // Next-state and datapath logic. The timer wraps at T_LAST, so a state
  // change taken at T_LAST already lands on a cleared timer.
  always_comb begin
    state_d        = state_q;
    timer_d        = (timer_q == T_LAST) ? T_ZERO : (timer_q + T_ONE);
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    frame_error_d  = frame_error_q;
    parity_error_d = parity_error_q;
`ifdef UART_RX_PARITY_EN
    parity_bit_d   = parity_bit_q;
`endif

    case (state_q)
      IDLE: begin
        timer_d   = T_ZERO;
        bit_cnt_d = 3'd0;
        if (!rx_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        if (timer_q == T_HALF) begin
          timer_d = T_ZERO;
          // Line back high at mid-start means it was only a glitch.
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = START;
        end
      end

      DATA: begin
        if (timer_q == T_LAST) begin
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
`ifdef UART_RX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (timer_q == T_LAST) begin
          parity_bit_d = rx_s;
          state_d      = STOP;
        end else begin
          state_d = PARITY;
        end
      end
`endif

      STOP: begin
        if (timer_q == T_LAST) begin
          rx_data_d     = shift_q;
          frame_error_d = ~rx_s;
          rx_valid_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
          parity_error_d = ^{shift_q, parity_bit_q};
`else
          parity_error_d = 1'b0;
`endif
          // A low stop bit means the line may be held in break; wait it out
          // instead of decoding a stream of 0x00 frames.
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = BREAK;
          end
        end else begin
          state_d = STOP;
        end
      end

      BREAK: begin
        timer_d = T_ZERO;
        if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = BREAK;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = T_ZERO;
      end
    endcase
  end

  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.frame_error  = frame_error_q;
  assign bus.parity_error = parity_error_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Purpose : Self-checking bench for uart_rx with CLKS_PER_BIT = 16. Each
//           frame sent pushes its expected result onto a scoreboard queue; a
//           monitor pops and compares on every rx_valid strobe.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  uart_rx_if rx_if ();

  int   n_checks = 0;
  int   n_fail   = 0;
  int   valid_cnt = 0;
  int   cyc = 0;
  int   prev_valid_cyc = 0;
  int   last_valid_cyc = 0;
  logic prev_valid = 1'b0;
  exp_t exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rx_if.master)
  );

  always #5 clk = ~clk;

  // Cycle counter for measuring spacing between valid strobes.
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every rx_valid strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rx_if.rx_valid === 1'b1) begin
      valid_cnt++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      n_checks++;
      if (prev_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL valid_width: rx_valid high %0d cycles in a row, required 1", 2);
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: rx_valid with data %h, none expected", rx_if.rx_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks += 3;
        if (rx_if.rx_data !== e.data) begin
          n_fail++;
          $display("FAIL sb_data: got %h, expected %h", rx_if.rx_data, e.data);
        end
        if (rx_if.frame_error !== e.fe) begin
          n_fail++;
          $display("FAIL sb_frame_error: got %b, expected %b", rx_if.frame_error, e.fe);
        end
        if (rx_if.parity_error !== e.pe) begin
          n_fail++;
          $display("FAIL sb_parity_error: got %b, expected %b", rx_if.parity_error, e.pe);
        end
      end
    end
    prev_valid = rx_if.rx_valid;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    rx_if.serial_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Drives one frame and pushes its expected outcome.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    exp_t e;
    e.data = d;
    e.fe   = ~stop;
`ifdef UART_RX_PARITY_EN
    e.pe   = ^{d, par};
`else
    e.pe   = 1'b0;
`endif
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 20 * CPB && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d frames still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rx_if.serial_in = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks += 5;
    if (rx_if.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h, expected 00", rx_if.rx_data); end
    if (rx_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", rx_if.rx_valid); end
    if (rx_if.frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b, expected 0", rx_if.frame_error); end
    if (rx_if.parity_error !== 1'b0) begin n_fail++; $display("FAIL reset_pe: got %b, expected 0", rx_if.parity_error); end
    if (rx_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", rx_if.busy); end
    reset = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic test_basic();
    int v0;
    v0 = valid_cnt;
    send_frame(8'hA5, ^8'hA5, 1'b1);
    wait_empty("basic");
    n_checks += 4;
    if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL basic_count: got %0d pulses, expected 1", valid_cnt - v0); end
    if (rx_if.rx_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h, expected a5", rx_if.rx_data); end
    if (rx_if.frame_error !== 1'b0) begin n_fail++; $display("FAIL basic_fe: got %b, expected 0", rx_if.frame_error); end
    if (rx_if.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b, expected 0", rx_if.busy); end
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_cnt;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    wait_empty("b2b");
    n_checks += 3;
    if (valid_cnt - v0 !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d pulses, expected 2", valid_cnt - v0); end
    if (last_valid_cyc - prev_valid_cyc !== 10 * CPB) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d cycles, expected %0d", last_valid_cyc - prev_valid_cyc, 10 * CPB);
    end
    if (rx_if.rx_data !== 8'hFF) begin n_fail++; $display("FAIL b2b_data: got %h, expected ff", rx_if.rx_data); end
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_false_start();
    int v0;
    v0 = valid_cnt;
    rx_if.serial_in = 1'b0;
    repeat (4) @(negedge clk);
    rx_if.serial_in = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rx_if.busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high: got %b, expected 1", rx_if.busy); end
    repeat (6) @(negedge clk);
    n_checks++;
    if (rx_if.busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_low: got %b, expected 0", rx_if.busy); end
    repeat (2 * CPB) @(negedge clk);
    n_checks++;
    if (valid_cnt !== v0) begin n_fail++; $display("FAIL glitch_no_valid: got %0d pulses, expected 0", valid_cnt - v0); end
    send_frame(8'h3C, ^8'h3C, 1'b1);
    wait_empty("after_glitch");
    n_checks++;
    if (rx_if.rx_data !== 8'h3C) begin n_fail++; $display("FAIL glitch_data: got %h, expected 3c", rx_if.rx_data); end
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_break();
    int v0;
    v0 = valid_cnt;
    send_frame(8'h55, ^8'h55, 1'b0);
    rx_if.serial_in = 1'b0;
    repeat (40) @(negedge clk);
    wait_empty("break");
    n_checks += 4;
    if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL break_count: got %0d pulses, expected 1", valid_cnt - v0); end
    if (rx_if.frame_error !== 1'b1) begin n_fail++; $display("FAIL break_fe: got %b, expected 1", rx_if.frame_error); end
    if (rx_if.rx_data !== 8'h55) begin n_fail++; $display("FAIL break_data: got %h, expected 55", rx_if.rx_data); end
    if (rx_if.busy !== 1'b1) begin n_fail++; $display("FAIL break_busy: got %b, expected 1", rx_if.busy); end
    rx_if.serial_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    n_checks += 2;
    if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL break_extra: got %0d pulses, expected 1", valid_cnt - v0); end
    if (rx_if.busy !== 1'b0) begin n_fail++; $display("FAIL break_idle: got %b, expected 0", rx_if.busy); end
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    logic [7:0] d;
    v0 = valid_cnt;
    d = 8'h81;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx_if.serial_in = d[4];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b0;
    rx_if.serial_in = 1'b1;
    repeat (2) @(negedge clk);
    n_checks += 4;
    if (rx_if.rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h, expected 00", rx_if.rx_data); end
    if (rx_if.frame_error !== 1'b0) begin n_fail++; $display("FAIL midrst_fe: got %b, expected 0", rx_if.frame_error); end
    if (rx_if.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, expected 0", rx_if.busy); end
    if (rx_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, expected 0", rx_if.rx_valid); end
    reset = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    n_checks++;
    if (valid_cnt !== v0) begin n_fail++; $display("FAIL midrst_no_valid: got %0d pulses, expected 0", valid_cnt - v0); end
    send_frame(8'h81, ^8'h81, 1'b1);
    wait_empty("midrst");
    n_checks++;
    if (rx_if.rx_data !== 8'h81) begin n_fail++; $display("FAIL midrst_next: got %h, expected 81", rx_if.rx_data); end
    repeat (CPB) @(negedge clk);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b1, 1'b1);
    wait_empty("parity_good");
    n_checks++;
    if (rx_if.parity_error !== 1'b0) begin n_fail++; $display("FAIL parity_good: got %b, expected 0", rx_if.parity_error); end
    send_frame(8'h07, 1'b0, 1'b1);
    wait_empty("parity_bad");
    n_checks += 2;
    if (rx_if.parity_error !== 1'b1) begin n_fail++; $display("FAIL parity_bad: got %b, expected 1", rx_if.parity_error); end
    if (rx_if.rx_data !== 8'h07) begin n_fail++; $display("FAIL parity_data: got %h, expected 07", rx_if.rx_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_false_start();
    test_break();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected frames never seen, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
